// File: rtl/duc_model_path_basename_stream.sv
// Streaming basename extractor: collects a path one byte per beat, keeps only the
// component after the last separator, then replays it as a byte stream.
module duc_model_path_basename_stream #(
  parameter int         MAX_LEN = 512,
  parameter logic [7:0] SEP     = 8'h2F
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [7:0]                       in_data,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [7:0]                       out_data,
  output logic                             out_last,
  output logic [$clog2(MAX_LEN+1)-1:0]     out_len,
  output logic                             out_overflow
);
  localparam int LW = $clog2(MAX_LEN+1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LW-1:0] FULL = LW'(MAX_LEN);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] EMIT    = 1'b1;

  logic [0:0]    state;
  logic          rdy;
  logic [LW-1:0] wr_ptr, rd_ptr, len;
  logic          ovf, len_ovf;
  logic [7:0]    mem [MAX_LEN];

  logic          in_acc, is_sep, is_pad, do_wr, ovf_nxt;
  logic [LW-1:0] wr_nxt;

  assign in_ready     = rdy;
  assign in_acc       = in_valid && rdy;
  assign out_valid    = (state == EMIT);
  assign out_len      = len;
  assign out_overflow = len_ovf;
  assign out_last     = out_valid && ((len == '0) || (rd_ptr == len - 1'b1));
  // An empty basename still presents one beat, carrying a zero byte.
  assign out_data     = (out_valid && len != '0) ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_comb begin
    is_sep  = (in_data == SEP);
    is_pad  = (in_data == 8'h00);
    wr_nxt  = wr_ptr;
    ovf_nxt = ovf;
    do_wr   = 1'b0;
    if (is_sep) begin
      wr_nxt  = '0;
      ovf_nxt = 1'b0;
    end else if (!is_pad) begin
      if (wr_ptr < FULL) begin
        wr_nxt = wr_ptr + 1'b1;
        do_wr  = in_acc;
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state   <= COLLECT;
      rdy     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len     <= '0;
      ovf     <= 1'b0;
      len_ovf <= 1'b0;
    end else if (state == COLLECT) begin
      rdy <= 1'b1;
      if (in_acc) begin
        wr_ptr <= wr_nxt;
        ovf    <= ovf_nxt;
        if (in_last) begin
          len     <= wr_nxt;
          len_ovf <= ovf_nxt;
          rd_ptr  <= '0;
          state   <= EMIT;
          rdy     <= 1'b0;
        end
      end
    end else if (out_ready) begin
      if (out_last) begin
        state  <= COLLECT;
        rdy    <= 1'b1;
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
      end else begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is never cleared; only the pointers bound what is replayed.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= in_data;
  end
endmodule

// File: tb/tb_duc_model_path_basename_stream.sv
module tb_duc_model_path_basename_stream;
  localparam int         ML  = 4;
  localparam int         LW  = $clog2(ML+1);
  localparam logic [7:0] SEP = 8'h2F;

  logic          clk = 1'b0, areset = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, out_valid, out_last, out_overflow;
  logic [7:0]    out_data;
  logic [LW-1:0] out_len;

  int checks = 0, errors = 0;

  duc_model_path_basename_stream #(.MAX_LEN(ML), .SEP(SEP)) dut (
    .clk(clk), .areset(areset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_len(out_len), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] cur[$], exp_q[$], got[$], pq[$];
  int  exp_len = 0, idx = 0, last_len = 0, rmode = 0, bp_cnt = 0;
  bit  exp_ovf = 1'b0, emit = 1'b0, chk_en = 1'b0, last_ovf = 1'b0;

  function automatic void build_exp();
    int start = 0;
    for (int i = 0; i < cur.size(); i++) if (cur[i] == SEP) start = i + 1;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = start; i < cur.size(); i++)
      if (cur[i] != 8'h00) begin
        if (exp_q.size() < ML) exp_q.push_back(cur[i]);
        else exp_ovf = 1'b1;
      end
    exp_len = exp_q.size();
  endfunction

  always @(negedge clk) begin
    if (areset || !chk_en) begin
      emit = 1'b0;
      idx  = 0;
      cur.delete();
    end else if (emit) begin
      chk("out_valid_emit", 32'(out_valid), 32'd1);
      chk("in_ready_emit", 32'(in_ready), 32'd0);
      if (exp_len == 0) chk("out_data_empty", 32'(out_data), 32'd0);
      else              chk("out_data", 32'(out_data), 32'(exp_q[idx]));
      chk("out_last", 32'(out_last), 32'((exp_len == 0) || (idx == exp_len - 1)));
      chk("out_len", 32'(out_len), 32'(exp_len));
      chk("out_overflow", 32'(out_overflow), 32'(exp_ovf));
      if (out_ready) begin
        got.push_back(out_data);
        if (exp_len == 0 || idx == exp_len - 1) begin
          last_len = int'(out_len);
          last_ovf = out_overflow;
          emit = 1'b0;
          idx  = 0;
        end else idx++;
      end
    end else begin
      chk("out_valid_collect", 32'(out_valid), 32'd0);
      chk("in_ready_collect", 32'(in_ready), 32'd1);
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (in_last) begin
          build_exp();
          cur.delete();
          emit = 1'b1;
          idx  = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        out_ready = (bp_cnt >= 5) && bp_cnt[0];
        if (out_valid) bp_cnt++; else bp_cnt = 0;
      end
    endcase
  end

  task automatic wait_collect();
    int t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 500);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL emit_timeout: in_ready still %0b after %0d cycles", in_ready, t);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input bit gaps, input bit waitc);
    int t;
    bit acc;
    for (int i = 0; i < pq.size(); i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = pq[i];
      in_last  = (i == pq.size() - 1);
      t = 0;
      do begin @(negedge clk); acc = in_ready; @(posedge clk); #1; t++; end
      while (!acc && t < 500);
      if (!acc) begin
        checks++; errors++;
        $display("FAIL accept_timeout: byte %0d not accepted after %0d cycles", i, t);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (waitc) wait_collect();
  endtask

  task automatic load(input string s);
    pq.delete();
    for (int i = 0; i < s.len(); i++) pq.push_back(s[i]);
  endtask

  task automatic run(input string s);
    load(s);
    send(1'b0, 1'b1);
  endtask

  task automatic expect_got(input string s, input int len, input bit ovf);
    if (len == 0) begin
      chk("got_size", 32'(got.size()), 32'd1);
      if (got.size() > 0) chk("got_byte", 32'(got[0]), 32'd0);
    end else begin
      chk("got_size", 32'(got.size()), 32'(s.len()));
      for (int i = 0; i < s.len(); i++)
        if (i < got.size()) chk("got_byte", 32'(got[i]), 32'(s[i]));
    end
    chk("last_len", 32'(last_len), 32'(len));
    chk("last_ovf", 32'(last_ovf), 32'(ovf));
    got.delete();
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_len", 32'(out_len), 32'd0);
    chk("rst_out_overflow", 32'(out_overflow), 32'd0);
    areset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    chk_en = 1'b1;

    run("a/bc/def");   expect_got("def", 3, 1'b0);
    run("abc");        expect_got("abc", 3, 1'b0);
    run("ab/");        expect_got("", 0, 1'b0);
    pq = '{8'h00, 8'h00, 8'h00};
    send(1'b0, 1'b1);  expect_got("", 0, 1'b0);
    rmode = 2;
    run("x/y");        expect_got("y", 1, 1'b0);
    rmode = 0;
    run("p/123456");   expect_got("1234", 4, 1'b1);
    run("123456/ab");  expect_got("ab", 2, 1'b0);
    run("abcd/");      expect_got("", 0, 1'b0);
    pq = '{8'h61, 8'h00, 8'h62, SEP, 8'h63, 8'h00, 8'h64};
    send(1'b0, 1'b1);  expect_got("cd", 2, 1'b0);

    load("x/abcd");
    send(1'b0, 1'b0);
    t = 0;
    do begin @(posedge clk); t++; end while (got.size() < 2 && t < 100);
    chk("mid_emit_got", 32'(got.size()), 32'd2);
    #3;
    areset = 1'b1;
    chk_en = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd0);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_out_last", 32'(out_last), 32'd0);
    chk("async_out_len", 32'(out_len), 32'd0);
    got.delete();
    @(posedge clk); #1;
    areset = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_pulse", 32'(in_ready), 32'd1);
    chk_en = 1'b1;
    run("q");          expect_got("q", 1, 1'b0);

    rmode = 1;
    repeat (60) begin
      int n;
      int r;
      n = $urandom_range(1, 11);
      pq.delete();
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r < 2)       pq.push_back(SEP);
        else if (r == 2) pq.push_back(8'h00);
        else             pq.push_back(8'(8'h61 + r));
      end
      send(1'b1, 1'b1);
      got.delete();
    end
    rmode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
